// File: rtl/pcie_ram_led_scanner.sv
// pcie_ram_led_scanner: scans LED PWM config from shared RAM, drives LEDs, writes status back
module pcie_ram_led_scanner #(
    parameter int DATA_W        = 64,
    parameter int ADDR_W        = 12,
    parameter int NUM_CH        = 4,
    parameter int BASE_ADDR     = 0,
    parameter int READ_LATENCY  = 1,
    parameter int SCAN_INTERVAL = 1024
) (
    input  logic                pcie_ram_clk_clk,
    input  logic                pcie_ram_reset_reset,
    output logic [ADDR_W-1:0]   pcie_ram_bus_address,
    output logic                pcie_ram_bus_chipselect,
    output logic                pcie_ram_bus_clken,
    output logic                pcie_ram_bus_write,
    output logic [DATA_W-1:0]   pcie_ram_bus_writedata,
    output logic [DATA_W/8-1:0] pcie_ram_bus_byteenable,
    input  logic [DATA_W-1:0]   pcie_ram_bus_readdata,
    output logic [NUM_CH-1:0]   led,
    output logic                busy,
    output logic                scan_done
);
    localparam int CNT_W = DATA_W / 2;
    localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RD_CTRL   = 3'd1;
    localparam logic [2:0] WAIT_CTRL = 3'd2;
    localparam logic [2:0] RD_CFG    = 3'd3;
    localparam logic [2:0] WAIT_CFG  = 3'd4;
    localparam logic [2:0] WR_STAT   = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    logic              clk, rst;
    logic [2:0]        state_q, state_d;
    logic [31:0]       iv_q, iv_d;
    logic [1:0]        w_q, w_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              en_q, inv_q;
    logic [NUM_CH-1:0] led_q, led_d;
    logic [CNT_W-1:0]  per_q [NUM_CH];
    logic [CNT_W-1:0]  on_q  [NUM_CH];
    logic [CNT_W-1:0]  ph_q  [NUM_CH];
    logic [CNT_W-1:0]  ph_d  [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic              smp, ld_ctrl, ld_cfg;
    logic [CNT_W-1:0]  new_per, new_on;
    logic [ADDR_W-1:0] cfg_addr;

    assign clk      = pcie_ram_clk_clk;
    assign rst      = pcie_ram_reset_reset;
    assign smp      = w_q == 2'(READ_LATENCY - 1);
    assign ld_ctrl  = state_q == WAIT_CTRL && smp;
    assign ld_cfg   = state_q == WAIT_CFG && smp;
    assign new_per  = pcie_ram_bus_readdata[CNT_W-1:0];
    assign new_on   = pcie_ram_bus_readdata[DATA_W-1:CNT_W];
    assign cfg_addr = ADDR_W'(BASE_ADDR + 2 * int'(ch_q));

    assign pcie_ram_bus_address    = state_q == RD_CTRL ? ADDR_W'(BASE_ADDR + 2 * NUM_CH) :
                                     state_q == RD_CFG  ? cfg_addr :
                                     state_q == WR_STAT ? cfg_addr + ADDR_W'(1) : '0;
    assign pcie_ram_bus_chipselect = state_q == RD_CTRL || state_q == RD_CFG || state_q == WR_STAT;
    assign pcie_ram_bus_write      = state_q == WR_STAT;
    assign pcie_ram_bus_writedata  = state_q == WR_STAT ?
                                     DATA_W'({per_q[ch_q] != '0, led_q[ch_q], cnt_q[ch_q]}) : '0;
    assign pcie_ram_bus_byteenable = '1;
    assign pcie_ram_bus_clken      = 1'b1;
    assign led                     = led_q;
    assign busy                    = state_q != IDLE;
    assign scan_done               = state_q == DONE;

    // Scan sequencer: interval wait, ctrl read, then read-config/write-status per channel
    always_comb begin
        state_d = state_q;
        iv_d    = iv_q;
        w_d     = '0;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                iv_d    = iv_q == 32'(SCAN_INTERVAL - 1) ? '0 : iv_q + 32'd1;
                state_d = iv_q == 32'(SCAN_INTERVAL - 1) ? RD_CTRL : IDLE;
            end
            RD_CTRL:   state_d = WAIT_CTRL;
            WAIT_CTRL: begin
                w_d     = smp ? '0 : w_q + 2'd1;
                state_d = smp ? RD_CFG : WAIT_CTRL;
                ch_d    = '0;
            end
            RD_CFG:    state_d = WAIT_CFG;
            WAIT_CFG: begin
                w_d     = smp ? '0 : w_q + 2'd1;
                state_d = smp ? WR_STAT : WAIT_CFG;
            end
            WR_STAT: begin
                state_d = ch_q == CH_W'(NUM_CH - 1) ? DONE : RD_CFG;
                ch_d    = ch_q + CH_W'(1);
            end
            default:   state_d = IDLE;
        endcase
    end

    // Per-channel phase advance with config-load restart rules, and registered LED value
    always_comb begin
        ph_d  = ph_q;
        led_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ph_d[i]  = (!en_q || per_q[i] == '0 || ph_q[i] >= per_q[i] - CNT_W'(1) ||
                        (ld_cfg && ch_q == CH_W'(i) && (new_per != per_q[i] || ph_q[i] >= new_per))) ?
                       '0 : ph_q[i] + CNT_W'(1);
            led_d[i] = en_q && ((per_q[i] != '0 && ph_q[i] < on_q[i]) ^ inv_q);
        end
    end

    // Sequencer state and ctrl shadow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            iv_q    <= '0;
            w_q     <= '0;
            ch_q    <= '0;
            en_q    <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iv_q    <= iv_d;
            w_q     <= w_d;
            ch_q    <= ch_d;
            if (ld_ctrl) begin
                en_q  <= pcie_ram_bus_readdata[0];
                inv_q <= pcie_ram_bus_readdata[1];
            end
        end
    end

    // Channel shadows, phases, LEDs and rising-edge counters
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                per_q[i] <= '0;
                on_q[i]  <= '0;
                ph_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            led_q <= led_d;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ld_cfg && ch_q == CH_W'(i)) begin
                    per_q[i] <= new_per;
                    on_q[i]  <= new_on;
                end
                ph_q[i]  <= ph_d[i];
                cnt_q[i] <= cnt_q[i] + CNT_W'(led_d[i] & ~led_q[i]);
            end
        end
    end
endmodule
